// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// strobes from a latched opcode, with a memory-wait watchdog and retired counter.
module multicycle_control #(
  parameter int OP_W    = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32,
  parameter int OP_R    = 0,
  parameter int OP_J    = 1,
  parameter int OP_BNE  = 2,
  parameter int OP_ADDI = 5,
  parameter int OP_SW   = 7,
  parameter int OP_LW   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [OP_W-1:0]  op,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             alu_ne,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_en,
  output logic             aluinb,
  output logic             rdst,
  output logic             dmem_req,
  output logic             dmwe,
  output logic             rwe,
  output logic             rwd,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {C_R, C_J, C_BNE, C_I, C_SW, C_LW} cls_t;

  state_t            state, state_next;
  cls_t              cls;
  logic [OP_W-1:0]   op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting, expired;

  always_comb begin
    case (op_q)
      OP_W'(OP_R):    cls = C_R;
      OP_W'(OP_J):    cls = C_J;
      OP_W'(OP_BNE):  cls = C_BNE;
      OP_W'(OP_SW):   cls = C_SW;
      OP_W'(OP_LW):   cls = C_LW;
      OP_W'(OP_ADDI): cls = C_I;
      default:        cls = C_I;
    endcase
  end

  assign waiting = (state == FETCH && !imem_ack) || (state == MEM && !dmem_ack);
  assign expired = waiting && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    alu_en     = 1'b0;
    aluinb     = 1'b0;
    rdst       = 1'b0;
    dmem_req   = 1'b0;
    dmwe       = 1'b0;
    rwe        = 1'b0;
    rwd        = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = DECODE;
        end else if (expired) begin
          state_next = HALT;
        end
      end
      DECODE: state_next = EXEC;
      EXEC: begin
        alu_en = 1'b1;
        aluinb = !(cls == C_R || cls == C_BNE);
        rdst   = (cls == C_R);
        case (cls)
          C_J: begin
            pc_we      = 1'b1;
            pc_sel     = 2'd2;
            state_next = FETCH;
          end
          C_BNE: begin
            pc_we      = alu_ne;
            pc_sel     = 2'd1;
            state_next = FETCH;
          end
          C_SW, C_LW: state_next = MEM;
          default:    state_next = WB;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmwe     = (cls == C_SW);
        if (dmem_ack)     state_next = (cls == C_LW) ? WB : FETCH;
        else if (expired) state_next = HALT;
      end
      WB: begin
        rwe        = 1'b1;
        rwd        = (cls == C_LW);
        rdst       = (cls == C_R);
        state_next = FETCH;
      end
      HALT: err = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  // wait_cnt only survives a cycle that stays put in FETCH/MEM without ack;
  // any other transition (including entry) leaves it cleared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= state_next;
      if (state == DECODE) op_q <= op;
      if (waiting && state_next == state) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                wait_cnt <= '0;
      if (state_next == FETCH && (state == EXEC || state == MEM || state == WB))
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (TIMEOUT=16/CNT_W=32 and
// TIMEOUT=4/CNT_W=4) share stimulus; a phase-level model supplies expectations.
module tb_multicycle_control;

  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;
  localparam int TO_B = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [4:0]  op = '0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, alu_ne = 1'b0;

  logic        a_imem_req, a_ir_we, a_pc_we, a_alu_en, a_aluinb, a_rdst;
  logic        a_dmem_req, a_dmwe, a_rwe, a_rwd, a_err;
  logic [1:0]  a_pc_sel;
  logic [31:0] a_retired;
  logic        b_imem_req, b_ir_we, b_pc_we, b_alu_en, b_aluinb, b_rdst;
  logic        b_dmem_req, b_dmwe, b_rwe, b_rwd, b_err;
  logic [1:0]  b_pc_sel;
  logic [3:0]  b_retired;

  logic        sel = 1'b0;
  logic [12:0] a_vec, b_vec, vec;
  logic [31:0] ret;
  int          checks = 0, errors = 0, n_done = 0;

  assign a_vec = {a_imem_req, a_ir_we, a_pc_we, a_pc_sel, a_alu_en, a_aluinb, a_rdst,
                  a_dmem_req, a_dmwe, a_rwe, a_rwd, a_err};
  assign b_vec = {b_imem_req, b_ir_we, b_pc_we, b_pc_sel, b_alu_en, b_aluinb, b_rdst,
                  b_dmem_req, b_dmwe, b_rwe, b_rwd, b_err};
  assign vec = sel ? b_vec : a_vec;
  assign ret = sel ? {28'd0, b_retired} : a_retired;

  always #5 clock = ~clock;

  multicycle_control dut_a (
    .clock(clock), .reset_n(reset_n), .op(op), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .alu_ne(alu_ne), .imem_req(a_imem_req), .ir_we(a_ir_we), .pc_we(a_pc_we),
    .pc_sel(a_pc_sel), .alu_en(a_alu_en), .aluinb(a_aluinb), .rdst(a_rdst),
    .dmem_req(a_dmem_req), .dmwe(a_dmwe), .rwe(a_rwe), .rwd(a_rwd), .err(a_err),
    .retired(a_retired)
  );

  multicycle_control #(.TIMEOUT(TO_B), .CNT_W(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .op(op), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .alu_ne(alu_ne), .imem_req(b_imem_req), .ir_we(b_ir_we), .pc_we(b_pc_we),
    .pc_sel(b_pc_sel), .alu_en(b_alu_en), .aluinb(b_aluinb), .rdst(b_rdst),
    .dmem_req(b_dmem_req), .dmwe(b_dmwe), .rwe(b_rwe), .rwd(b_rwd), .err(b_err),
    .retired(b_retired)
  );

  // Expected strobes for one cycle of an instruction, straight from the
  // per-phase output table; bit order matches a_vec/b_vec.
  function automatic logic [12:0] exp_vec(int ph, int opc, bit ack, bit ne);
    logic [12:0] v = '0;
    bit r  = (opc == 0);
    bit j  = (opc == 1);
    bit b  = (opc == 2);
    bit sw = (opc == 7);
    bit lw = (opc == 8);
    case (ph)
      PH_F: begin v[12] = 1'b1; if (ack) begin v[11] = 1'b1; v[10] = 1'b1; end end
      PH_E: begin
        v[7] = 1'b1; v[6] = !(r || b); v[5] = r;
        if (j)      begin v[10] = 1'b1; v[9:8] = 2'd2; end
        else if (b) begin v[10] = ne;   v[9:8] = 2'd1; end
      end
      PH_M: begin v[4] = 1'b1; v[3] = sw; end
      PH_W: begin v[2] = 1'b1; v[1] = lw; v[5] = r; end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_ret();
    return sel ? 32'(n_done % 16) : 32'(n_done);
  endfunction

  // Drives one instruction: (fw+1) FETCH cycles, DECODE, EXEC, then MEM for
  // (mw+1) cycles on loads/stores and WB where applicable. With hang set the
  // MEM phase runs TO_B cycles with no ack and the instruction does not retire.
  task automatic run_instr(input int opc, input int fw, input int mw, input bit ne,
                           input bit hang);
    bit          j = (opc == 1), b = (opc == 2), sw = (opc == 7), lw = (opc == 8);
    logic [12:0] e;
    int          nm;
    for (int k = 0; k <= fw; k++) begin
      @(posedge clock); #1;
      imem_ack = (k == fw); dmem_ack = 1'($urandom); alu_ne = 1'($urandom);
      op = 5'($urandom);
      @(negedge clock);
      e = exp_vec(PH_F, opc, k == fw, 1'b0);
      checks++;
      if (vec !== e) begin errors++; $display("FAIL fetch op=%0d k=%0d got %b want %b", opc, k, vec, e); end
      if (k == 0) begin
        checks++;
        if (ret !== exp_ret()) begin errors++; $display("FAIL retired got %0d want %0d", ret, exp_ret()); end
      end
    end
    @(posedge clock); #1;
    op = 5'(opc); imem_ack = 1'($urandom); dmem_ack = 1'($urandom); alu_ne = 1'($urandom);
    @(negedge clock);
    checks++;
    if (vec !== 13'd0) begin errors++; $display("FAIL decode op=%0d got %b want 0", opc, vec); end
    @(posedge clock); #1;
    op = 5'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
    alu_ne = b ? ne : 1'($urandom);
    @(negedge clock);
    e = exp_vec(PH_E, opc, 1'b0, alu_ne);
    checks++;
    if (vec !== e) begin errors++; $display("FAIL exec op=%0d got %b want %b", opc, vec, e); end
    if (sw || lw) begin
      nm = hang ? TO_B : mw + 1;
      for (int k = 0; k < nm; k++) begin
        @(posedge clock); #1;
        dmem_ack = !hang && (k == mw); imem_ack = 1'($urandom);
        alu_ne = 1'($urandom); op = 5'($urandom);
        @(negedge clock);
        e = exp_vec(PH_M, opc, 1'b0, 1'b0);
        checks++;
        if (vec !== e) begin errors++; $display("FAIL mem op=%0d k=%0d got %b want %b", opc, k, vec, e); end
      end
      if (hang) return;
    end
    if (!(j || b || sw)) begin
      @(posedge clock); #1;
      op = 5'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom); alu_ne = 1'($urandom);
      @(negedge clock);
      e = exp_vec(PH_W, opc, 1'b0, 1'b0);
      checks++;
      if (vec !== e) begin errors++; $display("FAIL wb op=%0d got %b want %b", opc, vec, e); end
    end
    n_done++;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    imem_ack = 1'($urandom); dmem_ack = 1'($urandom); alu_ne = 1'($urandom);
    #1;
    n_done = 0;
    checks++;
    if (a_vec !== 13'd0 || b_vec !== 13'd0) begin
      errors++; $display("FAIL reset_outputs got %b/%b want 0", a_vec, b_vec);
    end
    checks++;
    if (a_retired !== 32'd0 || b_retired !== 4'd0) begin
      errors++; $display("FAIL reset_retired got %0d/%0d want 0", a_retired, b_retired);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (vec !== 13'd0) begin errors++; $display("FAIL idle got %b want 0", vec); end
  endtask

  task automatic test_stream();
    int ops[5] = '{5, 0, 7, 8, 1};
    sel = 1'b0;
    test_reset();
    foreach (ops[i]) run_instr(ops[i], 0, 0, 1'b0, 1'b0);
    @(posedge clock); #1; imem_ack = 1'b0;
    @(negedge clock);
    checks++;
    if (a_retired !== 32'd5 || a_imem_req !== 1'b1) begin
      errors++; $display("FAIL stream_retired got %0d req=%b want 5 req=1", a_retired, a_imem_req);
    end
  endtask

  task automatic test_bne();
    sel = 1'b0;
    test_reset();
    run_instr(2, 0, 0, 1'b1, 1'b0);
    run_instr(2, 0, 0, 1'b0, 1'b0);
    run_instr(5, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_fetch_wait();
    sel = 1'b0;
    test_reset();
    run_instr(5, 5, 0, 1'b0, 1'b0);
    run_instr(0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (a_err !== 1'b0) begin errors++; $display("FAIL fetch_wait_err got %b want 0", a_err); end
  endtask

  task automatic test_timeout();
    sel = 1'b1;
    test_reset();
    run_instr(7, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      imem_ack = 1'($urandom); dmem_ack = 1'($urandom); alu_ne = 1'($urandom); op = 5'($urandom);
      @(negedge clock);
      checks++;
      if (b_vec !== 13'd1) begin errors++; $display("FAIL halt k=%0d got %b want 0000000000001", k, b_vec); end
    end
    checks++;
    if (b_retired !== 4'd0) begin errors++; $display("FAIL halt_retired got %0d want 0", b_retired); end
  endtask

  task automatic test_boundary();
    sel = 1'b1;
    test_reset();
    run_instr(8, 3, 3, 1'b0, 1'b0);
    run_instr(7, 0, 3, 1'b0, 1'b0);
    run_instr(5, 0, 0, 1'b0, 1'b0);
    checks++;
    if (b_err !== 1'b0) begin errors++; $display("FAIL boundary_err got %b want 0", b_err); end
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    test_reset();
    run_instr(5, 0, 0, 1'b0, 1'b0);
    run_instr(0, 1, 0, 1'b0, 1'b0);
    run_instr(8, 0, 0, 1'b0, 1'b1);
    test_reset();
    run_instr(1, 0, 0, 1'b0, 1'b0);
    run_instr(8, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    int pick[6] = '{0, 1, 2, 5, 7, 8};
    sel = 1'b1;
    test_reset();
    for (int i = 0; i < 17; i++)
      run_instr(pick[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'b0);
    @(posedge clock); #1; imem_ack = 1'b0;
    @(negedge clock);
    checks++;
    if (b_retired !== 4'd1) begin errors++; $display("FAIL wrap got %0d want 1", b_retired); end
  endtask

  task automatic test_random();
    sel = 1'b0;
    test_reset();
    for (int i = 0; i < 60; i++)
      run_instr($urandom_range(0, 31), $urandom_range(0, 6), $urandom_range(0, 6),
                1'($urandom), 1'b0);
    @(posedge clock); #1; imem_ack = 1'b0;
    @(negedge clock);
    checks++;
    if (a_retired !== 32'd60) begin errors++; $display("FAIL random_retired got %0d want 60", a_retired); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bne();
    test_fetch_wait();
    test_timeout();
    test_boundary();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
